shift_unit_arbiter: RTL and testbench
=====================================

Name: shift_unit_arbiter

Overview:
Shares one 32-bit rotate-right barrel shifter between NREQ requesters using round-robin arbitration. Each request carries data, a shift amount and an opcode. The block derives rotate-left, logical and arithmetic shifts from the single rotate-right datapath using amount negation and masking. Results are registered on a single response channel tagged with the requester id, with valid/ready backpressure. It sits between the integer issue ports and the shared shift resource.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, $clog2(NREQ) (min 1), width of the response id

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
req_data  in  NREQ x 32  operand
req_amt  in  NREQ x 5  shift amount
req_op  in  NREQ x 3  0 ROR, 1 ROL, 2 SHR, 3 SHL, 4 SRA, 5-7 reserved
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_data  out  32  result
rsp_id  out  IDW  index of the requester that owns this result
rsp_err  out  1  reserved opcode flag
op_count  out  16  accepted-request counter, saturating

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). On reset: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_count=0, RR pointer=NREQ-1 (so requester 0 has first priority). Any in-flight result is discarded.
- can_accept = !rsp_valid | rsp_ready.
- Grant: the first requester with req_valid set, searching from pointer+1 modulo NREQ. req_ready[g] = can_accept & granted. req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- A transfer is req_valid[g] & req_ready[g]. On a transfer:
  - pointer <= g
  - the response register loads the result, rsp_id <= g, rsp_valid <= 1
  - op_count increments, holding at 0xFFFF
- The pointer does not move without a transfer.
- If rsp_valid & rsp_ready and there is no new transfer, rsp_valid <= 0.
- While rsp_valid & !rsp_ready: all outputs except op_count are held stable and every req_ready bit is 0.
- Latency is 1 cycle from transfer to rsp_valid. Throughput is 1 result per cycle when rsp_ready is held high.
- Datapath is one shared rotate-right instance, ror(x,n):
  - ROR: ror(d, amt)
  - ROL: ror(d, (32-amt) mod 32); amt=0 gives d
  - SHR: ror(d, amt) & (32'hFFFFFFFF >> amt)
  - SHL: ror(d, (32-amt) mod 32) & (32'hFFFFFFFF << amt)
  - SRA: SHR result | (d[31] ? ~(32'hFFFFFFFF >> amt) : 0)
  - Reserved opcodes: rsp_data = d, rsp_err = 1. Otherwise rsp_err = 0.
- amt is 5 bits, so all amounts are 0..31 and there is no overflow case.
- Idle (no req_valid set): no grant, pointer unchanged, outputs held except that rsp_valid drops once consumed.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [2:0] shift_op_e {OP_ROR, OP_ROL, OP_SHR, OP_SHL, OP_SRA}
  - localparam DATA_W=32, AMT_W=5
  - function shift_mask(amt, left)
- Sub-module rr_arbiter (NREQ): valid vector, pointer and enable in; one-hot grant and index out.
- The rotate datapath reuses the existing barrel_shifter_32bit module, instantiated once.

Test Plan:
- Directed ops on req 0 with rsp_ready=1:
  - ROR 0x80000001 amt 1 -> 0xC0000000
  - ROL 0x80000001 amt 4 -> 0x00000018
  - SHR 0x80000000 amt 31 -> 0x00000001
  - SRA 0x80000000 amt 31 -> 0xFFFFFFFF
  - SHL 0x00000001 amt 0 -> 0x00000001
  - Each result appears exactly 1 cycle after its transfer.
- Fairness: req 0 and req 1 valid continuously, rsp_ready=1, after reset -> grants 0,1,0,1; rsp_id alternates; op_count=4 after 4 transfers.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 3 cycles -> rsp_data/rsp_id stable and req_ready=00 throughout. On release, the pending result drains and the next grant is taken in the same cycle.
- Reserved op 6, data 0x12345678 -> rsp_data=0x12345678, rsp_err=1. A following ROR amt 0 returns with rsp_err=0.
- Saturation: force 65537 transfers -> op_count=0xFFFF.
- Reset mid-stream: assert rst while rsp_valid=1 and pointer=0 -> rsp_valid=0 immediately. After release, with both requesters valid, the first grant goes to req 0.

Source files
------------

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and helpers for the shared shift-unit arbiter.
//                Opcode encoding, datapath widths and the shift mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // Codes 5..7 are reserved and flagged as errors by the datapath.
    typedef enum logic [2:0] {
        OP_ROR = 3'd0,
        OP_ROL = 3'd1,
        OP_SHR = 3'd2,
        OP_SHL = 3'd3,
        OP_SRA = 3'd4
    } shift_op_e;

    // Mask of the bits that survive a logical shift by amt.
    // left=1: bits [31:amt] kept, left=0: bits [31-amt:0] kept.
    function automatic logic [DATA_W-1:0] shift_mask(
        input logic [AMT_W-1:0] amt,
        input logic             left
    );
        logic [DATA_W-1:0] ones;
        ones = '1;
        return left ? (ones << amt) : (ones >> amt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_shifter_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shifter_32bit
//  Description : 32-bit logarithmic rotate-right barrel shifter.
//  Ports       : data_in  - operand
//                amt      - rotate amount (0..31)
//                data_out - data_in rotated right by amt
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter_32bit (
    input  logic [31:0] data_in,
    input  logic [4:0]  amt,
    output logic [31:0] data_out
);

    logic [31:0] stage;

    // Five stages rotating by 1, 2, 4, 8, 16 as selected by each amt bit.
    always_comb begin
        stage = data_in;
        for (int i = 0; i < 5; i++) begin
            if (amt[i]) begin
                stage = (stage >> (1 << i)) | (stage << (32 - (1 << i)));
            end
        end
        data_out = stage;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant selection. Searches the
//                valid vector starting at ptr+1 (mod NREQ).
//  Ports       : valid - request vector
//                ptr   - index of the last granted requester
//                en    - grant enable (grant forced to zero when low)
//                grant - one-hot grant
//                idx   - index of the selected requester (valid even when
//                        en is low, zero when nothing is requesting)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        grant = '0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
        if (en && found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_unit_arbiter
//  Description : Round-robin sharing of one rotate-right barrel shifter
//                between NREQ requesters. ROL/SHL/SHR/SRA are derived from
//                the rotator via amount negation and masking. One registered
//                response channel with valid/ready backpressure.
//  Ports       : clk, rst             - clock, async active-high reset
//                req_valid/req_ready  - per-requester handshake
//                req_data/amt/op      - per-requester operand, amount, opcode
//                rsp_valid/rsp_ready  - response handshake
//                rsp_data/id/err      - result, owner index, reserved-op flag
//                op_count             - saturating accepted-request counter
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
    input  logic [NREQ-1:0][AMT_W-1:0]   req_amt,
    input  logic [NREQ-1:0][2:0]         req_op,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [IDW-1:0]               rsp_id,
    output logic                         rsp_err,
    output logic [15:0]                  op_count
);

    logic              can_accept;
    logic              transfer;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW-1:0]    ptr;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic [2:0]        sel_op;
    logic              use_left;
    logic [AMT_W-1:0]  rot_amt;
    logic [DATA_W-1:0] rot_out;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] result;
    logic              result_err;

    // The response register can take a new result if empty or draining now.
    assign can_accept = !rsp_valid || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .en    (can_accept),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign req_ready = grant;
    assign transfer  = |(req_valid & grant);

    assign sel_data = req_data[gnt_idx];
    assign sel_amt  = req_amt[gnt_idx];
    assign sel_op   = req_op[gnt_idx];

    // A left rotate by n equals a right rotate by (32-n) mod 32, which is
    // simply the 5-bit two's complement of n.
    assign use_left = (sel_op == OP_ROL) || (sel_op == OP_SHL);
    assign rot_amt  = use_left ? (AMT_W'(0) - sel_amt) : sel_amt;
    assign mask     = shift_mask(sel_amt, sel_op == OP_SHL);

    barrel_shifter_32bit u_rot (
        .data_in  (sel_data),
        .amt      (rot_amt),
        .data_out (rot_out)
    );

    always_comb begin
        result     = sel_data;
        result_err = 1'b0;
        case (sel_op)
            OP_ROR, OP_ROL: result = rot_out;
            OP_SHR, OP_SHL: result = rot_out & mask;
            // Sign fill occupies exactly the bits the logical mask cleared.
            OP_SRA:         result = (rot_out & mask) |
                                     (sel_data[DATA_W-1] ? ~mask : '0);
            default:        result_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= IDW'(NREQ - 1);
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            if (transfer) begin
                ptr       <= gnt_idx;
                rsp_valid <= 1'b1;
                rsp_data  <= result;
                rsp_id    <= gnt_idx;
                rsp_err   <= result_err;
                if (op_count != 16'hFFFF) begin
                    op_count <= op_count + 16'd1;
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_unit_arbiter
//  Description : Self-checking bench for shift_unit_arbiter (NREQ=2) with a
//                behavioural reference model of arbitration and shifting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_unit_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][31:0]  req_data;
    logic [NREQ-1:0][4:0]   req_amt;
    logic [NREQ-1:0][2:0]   req_op;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [31:0]            rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   rsp_err;
    logic [15:0]            op_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    logic        m_err;
    int          m_count;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    // Shift semantics from plain arithmetic; bit 32 is the error flag.
    function automatic logic [32:0] ref_op(input logic [31:0] d, input int n, input int op);
        logic [63:0] dd;
        logic [31:0] r;
        logic        err;
        dd  = {d, d};
        r   = d;
        err = 1'b0;
        case (op)
            0: begin dd = dd >> n; r = dd[31:0];  end
            1: begin dd = dd << n; r = dd[63:32]; end
            2: r = d >> n;
            3: r = d << n;
            4: r = $signed(d) >>> n;
            default: err = 1'b1;
        endcase
        return {err, r};
    endfunction

    function automatic int find_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready_vec();
        logic [NREQ-1:0] v;
        int g;
        v = '0;
        if (!m_valid || rsp_ready) begin
            g = find_grant(req_valid, m_ptr);
            if (g >= 0) v[g] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_ptr   = NREQ - 1;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        logic [NREQ-1:0] rdy;
        logic [32:0]     r;
        int              g;
        rdy = exp_ready_vec();
        g   = -1;
        for (int k = 0; k < NREQ; k++) if (rdy[k] && req_valid[k]) g = k;
        if (g >= 0) begin
            r       = ref_op(req_data[g], int'(req_amt[g]), int'(req_op[g]));
            m_ptr   = g;
            m_valid = 1'b1;
            m_data  = r[31:0];
            m_err   = r[32];
            m_id    = g;
            if (m_count < 65535) m_count++;
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0 || rsp_err !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: got v=%b d=%h id=%h e=%b, want all zero",
                                     rsp_valid, rsp_data, rsp_id, rsp_err); end
        checks++;
        if (op_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", op_count); end
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_priority: got %b want 01", req_ready); end
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b want 00", req_ready); end
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] td [5] = '{32'h80000001, 32'h80000001, 32'h80000000, 32'h80000000, 32'h00000001};
        logic [4:0]  ta [5] = '{5'd1, 5'd4, 5'd31, 5'd31, 5'd0};
        logic [2:0]  tp [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
        logic [31:0] te [5] = '{32'hC0000000, 32'h00000018, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid   = 2'b01;
            req_data[0] = td[i];
            req_amt[0]  = ta[i];
            req_op[0]   = tp[i];
            #1;
            checks++;
            if (req_ready !== 2'b01) begin errors++; $display("FAIL directed_ready[%0d]: got %b want 01", i, req_ready); end
            tick();
            req_valid = '0;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== te[i] || rsp_id !== 1'b0 || rsp_err !== 1'b0)
                begin errors++; $display("FAIL directed_result[%0d]: got v=%b d=%h id=%h e=%b want v=1 d=%h id=0 e=0",
                                         i, rsp_valid, rsp_data, rsp_id, rsp_err, te[i]); end
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL directed_drain[%0d]: got %b want 0", i, rsp_valid); end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 2'b11;
        req_data  = {32'hBBBB0001, 32'hAAAA0000};
        req_amt   = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, req_ready,
                                         (i % 2 == 0) ? 2'b01 : 2'b10); end
            tick();
            checks++;
            if (rsp_id !== IDW'(i % 2)) begin errors++; $display("FAIL fair_id[%0d]: got %0d want %0d", i, rsp_id, i % 2); end
        end
        checks++;
        if (op_count !== 16'd4) begin errors++; $display("FAIL fair_count: got %0d want 4", op_count); end
    endtask

    task automatic test_backpressure();
        // Continues with both requesters valid and a result pending.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 00", i, req_ready); end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== m_data || rsp_id !== IDW'(m_id))
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                                         i, rsp_valid, rsp_data, rsp_id, m_data, m_id); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== exp_ready_vec() || req_ready === 2'b00)
            begin errors++; $display("FAIL bp_release_grant: got %b want %b", req_ready, exp_ready_vec()); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== m_data || rsp_id !== IDW'(m_id))
            begin errors++; $display("FAIL bp_next: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                                     rsp_valid, rsp_data, rsp_id, m_data, m_id); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reserved();
        rsp_ready   = 1'b1;
        req_valid   = 2'b01;
        req_data[0] = 32'h12345678;
        req_amt[0]  = 5'd7;
        req_op[0]   = 3'd6;
        #1;
        tick();
        req_data[0] = 32'hCAFEF00D;
        req_amt[0]  = 5'd0;
        req_op[0]   = 3'd0;
        #1;
        checks++;
        if (rsp_data !== 32'h12345678 || rsp_err !== 1'b1)
            begin errors++; $display("FAIL reserved_op: got d=%h e=%b want d=12345678 e=1", rsp_data, rsp_err); end
        tick();
        checks++;
        if (rsp_data !== 32'hCAFEF00D || rsp_err !== 1'b0)
            begin errors++; $display("FAIL after_reserved: got d=%h e=%b want d=cafef00d e=0", rsp_data, rsp_err); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom_range(0, 3));
            for (int r = 0; r < NREQ; r++) begin
                req_data[r] = $urandom;
                req_amt[r]  = 5'($urandom_range(0, 31));
                req_op[r]   = 3'($urandom_range(0, 7));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (req_ready !== exp_ready_vec())
                begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, exp_ready_vec()); end
            checks++;
            if (rsp_valid !== m_valid || op_count !== 16'(m_count))
                begin errors++; $display("FAIL rand_state[%0d]: got v=%b cnt=%0d want v=%b cnt=%0d",
                                         i, rsp_valid, op_count, m_valid, m_count); end
            if (m_valid) begin
                checks++;
                if (rsp_data !== m_data || rsp_id !== IDW'(m_id) || rsp_err !== m_err)
                    begin errors++; $display("FAIL rand_rsp[%0d]: got d=%h id=%0d e=%b want d=%h id=%0d e=%b",
                                             i, rsp_data, rsp_id, rsp_err, m_data, m_id, m_err); end
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready   = 1'b1;
        req_valid   = 2'b01;
        req_op[0]   = 3'd0;
        req_amt[0]  = 5'd3;
        req_data[0] = 32'h0000FFFF;
        #1;
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", rsp_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'h0 || rsp_data !== 32'h0)
            begin errors++; $display("FAIL midrst_async: got v=%b cnt=%h d=%h want 0", rsp_valid, op_count, rsp_data); end
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant: got %b want 01", req_ready); end
        tick();
        checks++;
        if (rsp_id !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_id: got id=%0d v=%b want 0/1", rsp_id, rsp_valid); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid   = 2'b01;
        req_op[0]   = 3'd0;
        req_amt[0]  = 5'd0;
        req_data[0] = 32'h1;
        rsp_ready   = 1'b1;
        #1;
        repeat (65534) tick();
        checks++;
        if (op_count !== 16'hFFFE) begin errors++; $display("FAIL sat_below: got %h want fffe", op_count); end
        repeat (3) tick();
        checks++;
        if (op_count !== 16'hFFFF || op_count !== 16'(m_count))
            begin errors++; $display("FAIL sat_hold: got %h want ffff", op_count); end
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_fairness();
        test_backpressure();
        test_reserved();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
